// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_stream stream demultiplexer.
// Optional feature macro: DEMUX_AUTO_SEQ_EN (round-robin targeting, see demux_stream).
package demux_pkg;

  // Supported channel-count range
  localparam int unsigned NCH_MIN = 2;
  localparam int unsigned NCH_MAX = 16;

  // Widest payload the zero constant covers; narrower slots take a width-cast slice
  localparam int unsigned DW_MAX = 64;
  localparam logic [DW_MAX-1:0] ZERO_DATA = '0;

  // Select width for n channels; never below one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry output slot of demux_stream: holds a beat until its consumer takes it.
// An empty slot presents zero data.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  // Load has priority over drain so a same-cycle drain+load keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= DW'(ZERO_DATA);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= DW'(ZERO_DATA);
    end
  end

endmodule : demux_slot

// File: rtl/demux_stream.sv
// 1:NCH valid/ready stream demultiplexer with a registered one-entry slot per channel.
// Optional feature macro: DEMUX_AUTO_SEQ_EN adds the auto_seq port and a round-robin
// target pointer; without it targeting is by in_sel only.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int unsigned DW  = 8,
  parameter  int unsigned NCH = 4,
  localparam int unsigned SW  = sel_width(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
`ifdef DEMUX_AUTO_SEQ_EN
  input  logic              auto_seq,
`endif
  output logic              sel_err
);

  // Select space padded to a power of two so any select value indexes safely
  localparam int unsigned NPAD  = 1 << SW;
  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  logic [SW-1:0]   tgt;
  logic            sel_ok;
  logic            accept;
  logic [NPAD-1:0] vld_pad;
  logic [NPAD-1:0] rdy_pad;

`ifdef DEMUX_AUTO_SEQ_EN
  logic [SW-1:0] rr_ptr;

  // Target decode: round-robin pointer in auto mode, otherwise the explicit select
  assign tgt = auto_seq ? rr_ptr : in_sel;

  // Round-robin pointer advances per auto-mode accept and wraps at NCH-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && auto_seq) begin
      rr_ptr <= (rr_ptr == SW'(NCH - 1)) ? '0 : rr_ptr + SW'(1);
    end
  end
`else
  // Target decode: explicit select only
  assign tgt = in_sel;
`endif

  assign sel_ok  = {1'b0, tgt} < NCH_W;
  assign vld_pad = NPAD'(out_valid);
  assign rdy_pad = NPAD'(out_ready);

  // Ready when the target slot is empty or draining this cycle; bad selects always accept
  assign in_ready = rst_n && en && (!sel_ok || !vld_pad[tgt] || rdy_pad[tgt]);
  assign accept   = in_valid && in_ready;

  // One-cycle error pulse for an accepted beat with an out-of-range select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && !sel_ok;
    end
  end

  // Per-channel slots; only the decoded target loads
  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept && sel_ok && (tgt == SW'(k))),
      .load_data (in_data),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*DW +: DW])
    );
  end

endmodule : demux_stream

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: NCH=4 main instance plus an NCH=3 instance for
// out-of-range selects. Auto-sequencing vectors run when DEMUX_AUTO_SEQ_EN is defined.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst_n;

  // NCH=4 instance
  logic        a_en, a_in_valid, a_in_ready, a_sel_err;
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_sel;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  logic        a_auto_seq;

  // NCH=3 instance
  logic        b_en, b_in_valid, b_in_ready, b_sel_err;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_stream #(.DW(8), .NCH(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (a_en),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
`ifdef DEMUX_AUTO_SEQ_EN
    .auto_seq  (a_auto_seq),
`endif
    .sel_err   (a_sel_err)
  );

  demux_stream #(.DW(8), .NCH(3)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (b_en),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
`ifdef DEMUX_AUTO_SEQ_EN
    .auto_seq  (1'b0),
`endif
    .sel_err   (b_sel_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0;
    a_out_ready = '0; a_auto_seq = 1'b0;
    b_en = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0;
    b_out_ready = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 64'(a_out_valid), 64'h0);
    chk("rst_data", 64'(a_out_data), 64'h0);
    chk("rst_err", 64'(a_sel_err), 64'h0);
    a_in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'h0);
    a_in_valid = 1'b0;
    rst_n = 1'b1;

    // Route 0xA5 to channel 2
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'hA5;
    #1;
    chk("route_ready", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    chk("route_valid", 64'(a_out_valid), 64'h4);
    chk("route_data", 64'(a_out_data), 64'h00A5_0000);

    // Fill channel 1, then back-pressure on channel 1 while channel 3 still accepts
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h11;
    tick();
    chk("fill1_valid", 64'(a_out_valid), 64'h6);
    a_in_sel = 2'd1; a_in_data = 8'h22;
    #1;
    chk("bp_ready", 64'(a_in_ready), 64'h0);
    tick();
    chk("bp_hold_data", 64'(a_out_data), 64'h00A5_1100);
    a_in_sel = 2'd3; a_in_data = 8'h33;
    #1;
    chk("bp_other_ready", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    chk("bp_other_valid", 64'(a_out_valid), 64'hE);
    chk("bp_other_data", 64'(a_out_data), 64'h33A5_1100);

    // Back-to-back beats to channel 0 with its consumer ready: no bubbles
    a_out_ready = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'(i + 1);
      #1;
      chk($sformatf("stream_ready%0d", i), 64'(a_in_ready), 64'h1);
      tick();
      chk($sformatf("stream_valid%0d", i), 64'(a_out_valid[0]), 64'h1);
      chk($sformatf("stream_data%0d", i), 64'(a_out_data[7:0]), 64'(i + 1));
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(a_out_valid), 64'hE);
    chk("stream_zero", 64'(a_out_data[7:0]), 64'h0);

    // Enable low blocks accepts while channel 2 drains
    a_en = 1'b0; a_out_ready = 4'b0100;
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h44;
    #1;
    chk("en_ready", 64'(a_in_ready), 64'h0);
    tick();
    chk("en_drain_valid", 64'(a_out_valid), 64'hA);
    chk("en_drain_data", 64'(a_out_data), 64'h3300_1100);
    a_in_valid = 1'b0; a_en = 1'b1; a_out_ready = '0;

    // Asynchronous reset with two slots full clears immediately
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'h0);
    chk("mid_rst_data", 64'(a_out_data), 64'h0);
    chk("mid_rst_ready", 64'(a_in_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h5A;
    #1;
    chk("post_rst_ready", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    chk("post_rst_valid", 64'(a_out_valid), 64'h1);
    chk("post_rst_data", 64'(a_out_data), 64'h0000_005A);

    // NCH=3: park a beat in channel 1, then send an out-of-range select
    b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h77;
    tick();
    chk("b_load_valid", 64'(b_out_valid), 64'h2);
    b_in_sel = 2'd3; b_in_data = 8'hEE;
    #1;
    chk("b_bad_ready", 64'(b_in_ready), 64'h1);
    tick();
    b_in_valid = 1'b0;
    chk("b_bad_err", 64'(b_sel_err), 64'h1);
    chk("b_bad_valid", 64'(b_out_valid), 64'h2);
    chk("b_bad_data", 64'(b_out_data), 64'h00_7700);
    tick();
    chk("b_err_pulse", 64'(b_sel_err), 64'h0);
    chk("a_no_err", 64'(a_sel_err), 64'h0);

`ifdef DEMUX_AUTO_SEQ_EN
    // Round-robin targeting ignores in_sel and resumes after a stall
    a_out_ready = 4'hF;
    tick();
    chk("auto_idle", 64'(a_out_valid), 64'h0);
    a_auto_seq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_data = 8'(8'h10 + i);
      tick();
      chk($sformatf("auto_valid%0d", i), 64'(a_out_valid), 64'(4'b0001 << (i % 4)));
      chk($sformatf("auto_data%0d", i), 64'(a_out_data[(i % 4)*8 +: 8]), 64'(8'h10 + i));
    end
    a_in_valid = 1'b0;
    repeat (2) tick();
    chk("auto_stall", 64'(a_out_valid), 64'h0);
    a_in_valid = 1'b1; a_in_data = 8'h16;
    tick();
    a_in_valid = 1'b0;
    chk("auto_resume_valid", 64'(a_out_valid), 64'h4);
    chk("auto_resume_data", 64'(a_out_data), 64'h0016_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_demux_stream
